// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the data cache refill/write-back port.
// Services AXI-style read and write bursts from an internal word-addressed SRAM model.
module dcache_mem_responder #(
   parameter int MEM_AW = 12,
   parameter int RD_LAT = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        r_req,
   input  logic [31:0] r_addr,
   input  logic [2:0]  r_size,
   input  logic [7:0]  r_length,
   output logic        r_rdy,
   output logic        ret_valid,
   output logic        ret_last,
   output logic [31:0] r_data,
   input  logic        r_data_ready,
   input  logic        w_req,
   input  logic [31:0] w_addr,
   input  logic [2:0]  w_size,
   input  logic [7:0]  w_length,
   output logic        w_rdy,
   input  logic        w_data_req,
   input  logic [31:0] w_data,
   input  logic [3:0]  w_strb,
   input  logic        w_last,
   output logic        w_data_ready,
   output logic        b_valid,
   input  logic        b_ready,
   output logic        proto_err
);

   typedef enum logic [2:0] {IDLE, R_WAIT, R_BURST, W_DATA, W_RESP} state_e;

   state_e              state_q, state_d;
   logic [MEM_AW-1:0]   addr_q, addr_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [3:0]          lat_q, lat_d;
   logic                ret_valid_q, ret_valid_d;
   logic                ret_last_q, ret_last_d;
   logic [31:0]         r_data_q, r_data_d;
   logic                b_valid_q, b_valid_d;
   logic                proto_err_q, proto_err_d;

   logic [31:0]         mem [2**MEM_AW];
   logic [MEM_AW-1:0]   addr_inc;
   logic                wr_en;

   // Size fields and out-of-range address bits carry no meaning for this model.
   logic unused_ok;
   assign unused_ok = ^{r_size, w_size, r_addr[31:MEM_AW+2], r_addr[1:0],
                        w_addr[31:MEM_AW+2], w_addr[1:0]};

   assign addr_inc = addr_q + MEM_AW'(1);
   assign wr_en    = (state_q == W_DATA) && w_data_req;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      lat_d        = lat_q;
      ret_valid_d  = ret_valid_q;
      ret_last_d   = ret_last_q;
      r_data_d     = r_data_q;
      b_valid_d    = b_valid_q;
      proto_err_d  = proto_err_q;
      r_rdy        = 1'b0;
      w_rdy        = 1'b0;
      w_data_ready = 1'b0;

      case (state_q)
         IDLE: begin
            // Write wins so a victim write-back lands before the refill of the same line.
            w_rdy = 1'b1;
            r_rdy = !w_req;
            if (w_req) begin
               addr_d  = w_addr[MEM_AW+1:2];
               cnt_d   = w_length;
               state_d = W_DATA;
            end else if (r_req) begin
               addr_d  = r_addr[MEM_AW+1:2];
               cnt_d   = r_length;
               lat_d   = 4'(RD_LAT);
               state_d = R_WAIT;
            end
         end
         R_WAIT: begin
            if (lat_q == 4'd0) begin
               r_data_d    = mem[addr_q];
               ret_valid_d = 1'b1;
               ret_last_d  = (cnt_q == 8'd0);
               state_d     = R_BURST;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         R_BURST: begin
            if (ret_valid_q && r_data_ready) begin
               if (ret_last_q) begin
                  ret_valid_d = 1'b0;
                  ret_last_d  = 1'b0;
                  state_d     = IDLE;
               end else begin
                  addr_d     = addr_inc;
                  cnt_d      = cnt_q - 8'd1;
                  r_data_d   = mem[addr_inc];
                  ret_last_d = (cnt_q == 8'd1);
               end
            end
         end
         W_DATA: begin
            w_data_ready = 1'b1;
            if (w_data_req) begin
               addr_d = addr_inc;
               cnt_d  = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
               if ((w_last && cnt_q != 8'd0) || (!w_last && cnt_q == 8'd0))
                  proto_err_d = 1'b1;
               if (w_last) begin
                  b_valid_d = 1'b1;
                  state_d   = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (b_ready) begin
               b_valid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q     <= IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         lat_q       <= '0;
         ret_valid_q <= 1'b0;
         ret_last_q  <= 1'b0;
         r_data_q    <= '0;
         b_valid_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         lat_q       <= lat_d;
         ret_valid_q <= ret_valid_d;
         ret_last_q  <= ret_last_d;
         r_data_q    <= r_data_d;
         b_valid_q   <= b_valid_d;
         proto_err_q <= proto_err_d;
      end
   end

   // NOTE: the array is intentionally not reset; it models SRAM that simulation preloads.
   always_ff @(posedge clk) begin
      if (rstn && wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (w_strb[i]) mem[addr_q][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

   assign ret_valid = ret_valid_q;
   assign ret_last  = ret_last_q;
   assign r_data    = r_data_q;
   assign b_valid   = b_valid_q;
   assign proto_err = proto_err_q;

endmodule
